button_conditioner: RTL and testbench

- Parametrised multi-channel push-button front end for board-level top modules.
- Replaces one-debouncer-instance-per-button wiring.
- Each channel provides:
  - input inversion
  - two-flop synchronisation
  - counter-based debounce
  - a stable level, plus one-cycle press and release strobes
- Feeds calculator/UART control logic (push, execute, output-select buttons) directly from raw board pins.

---
 rtl/button_conditioner.sv | 126 ++++++++++++
 tb/tb_button_conditioner.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button front end: polarity fix, 2-flop sync, counter debounce, press/release strobes.
// Define BTN_AUTOREPEAT_EN to add hold-then-repeat Press pulses per channel.

module button_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic rel,
  output logic press_set
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_cfg_check
    $error("button_conditioner_lane: invalid timing parameters");
  end

  logic          raw, sync1, sync2;
  logic [CW-1:0] cnt;
  logic          accept, press_evt, rel_evt, rpt;

  assign raw       = (ACTIVE_LOW != 0) ? ~pin : pin;
  assign accept    = (sync2 != level) && (cnt == CNT_MAX);
  assign press_evt = accept && sync2;
  assign rel_evt   = accept && !sync2;
  assign press_set = press_evt | rpt;

  // Strobes come from the accept event, so a reset that clears level never fakes a release.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      press <= press_set;
      rel   <= rel_evt;
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int HW = $clog2((HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES) + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RPT_MAX  = HW'(REPEAT_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic          in_rpt;

  // First pulse after HOLD_CYCLES, then every REPEAT_CYCLES; suppressed in the release cycle.
  assign rpt = level && !rel_evt && (in_rpt ? (hold_cnt == RPT_MAX) : (hold_cnt == HOLD_MAX));

  always_ff @(posedge clk) begin
    if (rst || !level || rel_evt) begin
      hold_cnt <= '0;
      in_rpt   <= 1'b0;
    end else if (rpt) begin
      hold_cnt <= '0;
      in_rpt   <= 1'b1;
    end else begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end
`else
  assign rpt = 1'b0;
`endif
endmodule

module button_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [CHANNELS-1:0] Btn,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic                PressAny
);
  logic [CHANNELS-1:0] press_set;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    button_conditioner_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_lane (
      .clk      (Clk),
      .rst      (Rst),
      .pin      (Btn[i]),
      .level    (Level[i]),
      .press    (Press[i]),
      .rel      (Release[i]),
      .press_set(press_set[i])
    );
  end

  // Registered from the same next-state terms as Press so both land in one cycle.
  always_ff @(posedge Clk) begin
    if (Rst) PressAny <= 1'b0;
    else     PressAny <= |press_set;
  end
endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: reset, clean press/release, glitch, multi-channel, reset mid-hold, repeat.
module tb_button_conditioner;
  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] Btn;
  logic [3:0] Level, Press, Release;
  logic       PressAny;
  int checks = 0;
  int errors = 0;
  logic rpt_en;

  always #5 Clk = ~Clk;

  button_conditioner #(
    .CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1), .HOLD_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Btn(Btn), .Level(Level), .Press(Press), .Release(Release), .PressAny(PressAny)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                          input logic [3:0] rl, input logic pa);
    chk({tag, ".level"}, 32'(Level), 32'(lv));
    chk({tag, ".press"}, 32'(Press), 32'(pr));
    chk({tag, ".release"}, 32'(Release), 32'(rl));
    chk({tag, ".pressany"}, 32'(PressAny), 32'(pa));
  endtask

  initial begin
`ifdef BTN_AUTOREPEAT_EN
    rpt_en = 1'b1;
`else
    rpt_en = 1'b0;
`endif
    Rst = 1'b1;
    Btn = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_outs("reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    Rst = 1'b0;
    tick();
    chk_outs("post_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // clean press / release on channel 1
    Btn = 4'b1101;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_outs("press1_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_outs("press1_accept", 4'b0010, 4'b0010, 4'b0000, 1'b1);
    tick();
    chk_outs("press1_after", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    Btn = 4'b1111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_outs("rel1_wait", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_outs("rel1_accept", 4'b0000, 4'b0000, 4'b0010, 1'b0);
    tick();
    chk_outs("rel1_after", 4'b0000, 4'b0000, 4'b0000, 1'b0);

    // 3-cycle glitch on channel 2 must be rejected
    Btn = 4'b1011;
    tick(3);
    Btn = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_outs("glitch", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    // full latency afterwards shows the counter restarted from zero
    Btn = 4'b1011;
    tick(5);
    chk_outs("press2_wait5", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk_outs("press2_accept", 4'b0100, 4'b0100, 4'b0000, 1'b1);
    Btn = 4'b1111;
    tick(6);
    chk_outs("rel2_accept", 4'b0000, 4'b0000, 4'b0100, 1'b0);
    tick();

    // simultaneous press on channels 0 and 3
    Btn = 4'b0110;
    tick(5);
    chk_outs("sim_wait5", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    tick();
    chk_outs("sim_accept", 4'b1001, 4'b1001, 4'b0000, 1'b1);
    tick();
    chk_outs("sim_after", 4'b1001, 4'b0000, 4'b0000, 1'b0);
    Btn = 4'b0111;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_outs("rel0_wait", 4'b1001, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_outs("rel0_accept", 4'b1000, 4'b0000, 4'b0001, 1'b0);

    // reset while channel 3 is held
    Rst = 1'b1;
    tick();
    chk_outs("mid_rst", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    Rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk_outs("rst_reacq_wait", 4'b0000, 4'b0000, 4'b0000, 1'b0);
    end
    tick();
    chk_outs("rst_reacq", 4'b1000, 4'b1000, 4'b0000, 1'b1);
    Btn = 4'b1111;
    tick(6);
    chk_outs("rel3_accept", 4'b0000, 4'b0000, 4'b1000, 1'b0);
    tick(2);

    // long hold on channel 0: repeats only with auto-repeat enabled
    Btn = 4'b1110;
    tick(6);
    chk_outs("hold_accept", 4'b0001, 4'b0001, 4'b0000, 1'b1);
    for (int k = 1; k <= 52; k++) begin
      logic exp_p;
      tick();
      exp_p = rpt_en && (k == 20 || k == 28 || k == 36 || k == 44 || k == 52);
      chk($sformatf("hold_press_k%0d", k), 32'(Press), 32'({3'b000, exp_p}));
      chk($sformatf("hold_any_k%0d", k), 32'(PressAny), 32'(exp_p));
    end
    Btn = 4'b1111;
    for (int j = 1; j <= 12; j++) begin
      tick();
      chk($sformatf("hold_rel_press_j%0d", j), 32'(Press), 32'(0));
      chk($sformatf("hold_rel_release_j%0d", j), 32'(Release), (j == 6) ? 32'd1 : 32'd0);
    end
    chk("hold_final_level", 32'(Level), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
